pipeline_control: RTL

//  Central stall/flush sequencer for the 5-stage RV32 pipeline (fetch..writeback).

---
 rtl/pipeline_control_pkg.sv | 14 +
 rtl/pipeline_control_hazard_detect.sv | 24 ++
 rtl/pipeline_control.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/pipeline_control_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: state encodings and
// register-address width used by the hazard compare.
package pipeline_control_pkg;

  localparam int unsigned RegAddrW = 5;

  // Encodings are visible on the state port; the cpu debug/LED logic decodes them.
  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StMemWait = 2'd1,
    StFlush   = 2'd2
  } pc_state_e;

endpackage

// File: rtl/pipeline_control_hazard_detect.sv
// Load-use hazard compare between the load in execute and the instruction in decode.
module pipeline_control_hazard_detect
  import pipeline_control_pkg::*;
(
  input  logic [RegAddrW-1:0] de_rs1_i,
  input  logic [RegAddrW-1:0] de_rs2_i,
  input  logic                de_use_rs1_i,
  input  logic                de_use_rs2_i,
  input  logic                ex_mem_read_i,
  input  logic [RegAddrW-1:0] ex_reg_dest_i,
  output logic                lu_o
);

  logic rs1_hit;
  logic rs2_hit;

  always_comb begin
    rs1_hit = de_use_rs1_i && (de_rs1_i == ex_reg_dest_i);
    rs2_hit = de_use_rs2_i && (de_rs2_i == ex_reg_dest_i);
    // x0 never carries a dependency.
    lu_o    = ex_mem_read_i && (ex_reg_dest_i != '0) && (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/pipeline_control.sv
// Central stall/flush sequencer for the 5-stage pipeline: load-use stalls, memory-wait
// holds with timeout, and wrong-path flushes on taken branches, plus perf counters.
module pipeline_control
  import pipeline_control_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 3,
  parameter int unsigned MEM_TIMEOUT  = 16,
  parameter int unsigned COUNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [4:0]         de_rs1,
  input  logic [4:0]         de_rs2,
  input  logic               de_use_rs1,
  input  logic               de_use_rs2,
  input  logic               ex_MemRead,
  input  logic [4:0]         ex_RegDest,
  input  logic               mem_req,
  input  logic               mem_done,
  input  logic               branch_taken,
  output logic               stall_if,
  output logic               stall_de,
  output logic               stall_ex,
  output logic               stall_mem,
  output logic               bubble_ex,
  output logic               bubble_wb,
  output logic               flush_if_de,
  output logic               flush_de_ex,
  output logic               flush_ex_mem,
  output logic               mem_abort,
  output logic               mem_timeout,
  output logic [1:0]         state,
  output logic [COUNT_W-1:0] stall_cycles,
  output logic [COUNT_W-1:0] flush_events
);

  localparam int unsigned TmrW  = $clog2(MEM_TIMEOUT + 1);
  localparam int unsigned FcntW = $clog2(FLUSH_CYCLES + 1);

  localparam logic [TmrW-1:0]    TmrOne   = TmrW'(1);
  localparam logic [TmrW-1:0]    TmrLast  = TmrW'(MEM_TIMEOUT - 1);
  localparam logic [FcntW-1:0]   FcntOne  = FcntW'(1);
  localparam logic [FcntW-1:0]   FcntLoad = FcntW'(FLUSH_CYCLES - 1);
  localparam logic [COUNT_W-1:0] CntOne   = COUNT_W'(1);
  // A single-cycle flush is fully covered by the detect cycle.
  localparam pc_state_e StAfterBranch = (FLUSH_CYCLES == 1) ? StRun : StFlush;

  pc_state_e          state_q, state_d;
  logic [TmrW-1:0]    tmr_q, tmr_d;
  logic [FcntW-1:0]   fcnt_q, fcnt_d;
  logic               timeout_q, timeout_d;
  logic [COUNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [COUNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic lu;
  logic mw;
  logic mem_stall;
  logic lu_stall;
  logic flush;
  logic abort;
  logic flush_evt;

  pipeline_control_hazard_detect u_hazard_detect (
    .de_rs1_i      (de_rs1),
    .de_rs2_i      (de_rs2),
    .de_use_rs1_i  (de_use_rs1),
    .de_use_rs2_i  (de_use_rs2),
    .ex_mem_read_i (ex_MemRead),
    .ex_reg_dest_i (ex_RegDest),
    .lu_o          (lu)
  );

  assign mw = mem_req & ~mem_done;

  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    fcnt_d    = fcnt_q;
    timeout_d = timeout_q;
    mem_stall = 1'b0;
    lu_stall  = 1'b0;
    flush     = 1'b0;
    abort     = 1'b0;
    flush_evt = 1'b0;

    case (state_q)
      StRun: begin
        if (branch_taken) begin
          flush     = 1'b1;
          flush_evt = 1'b1;
          fcnt_d    = FcntLoad;
          state_d   = StAfterBranch;
        end else if (mw) begin
          mem_stall = 1'b1;
          tmr_d     = TmrOne;
          state_d   = StMemWait;
        end else if (lu) begin
          lu_stall = 1'b1;
        end
      end
      StMemWait: begin
        if (branch_taken) begin
          abort     = 1'b1;
          flush     = 1'b1;
          flush_evt = 1'b1;
          fcnt_d    = FcntLoad;
          tmr_d     = '0;
          state_d   = StAfterBranch;
        end else if (mem_done) begin
          tmr_d   = '0;
          state_d = StRun;
        end else if (tmr_q == TmrLast) begin
          abort     = 1'b1;
          timeout_d = 1'b1;
          tmr_d     = '0;
          state_d   = StRun;
        end else begin
          mem_stall = 1'b1;
          tmr_d     = tmr_q + TmrOne;
        end
      end
      StFlush: begin
        flush = 1'b1;
        if (branch_taken) begin
          flush_evt = 1'b1;
          fcnt_d    = FcntLoad;
        end else begin
          fcnt_d = fcnt_q - FcntOne;
          if (fcnt_q == FcntOne) begin
            state_d = StRun;
          end
        end
      end
      default: state_d = StRun;
    endcase

    stall_cnt_d = stall_cnt_q;
    if ((mem_stall || lu_stall) && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CntOne;
    end
    flush_cnt_d = flush_cnt_q;
    if (flush_evt && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CntOne;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StRun;
      tmr_q       <= '0;
      fcnt_q      <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (en) begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      fcnt_q      <= fcnt_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Pipeline-facing controls are masked while reset is held.
  always_comb begin
    stall_if     = ~rst & (mem_stall | lu_stall);
    stall_de     = ~rst & (mem_stall | lu_stall);
    stall_ex     = ~rst & mem_stall;
    stall_mem    = ~rst & mem_stall;
    bubble_ex    = ~rst & lu_stall;
    bubble_wb    = ~rst & mem_stall;
    flush_if_de  = ~rst & flush;
    flush_de_ex  = ~rst & flush;
    flush_ex_mem = ~rst & flush;
    mem_abort    = ~rst & abort;
    mem_timeout  = timeout_q;
    state        = state_q;
    stall_cycles = stall_cnt_q;
    flush_events = flush_cnt_q;
  end

endmodule
